// File: rtl/lfsr_timer_pkg.sv
// Shared constants and types for the Galois-LFSR interval timers.
package lfsr_timer_pkg;

  // Mode encodings select which terminal state a reconfig loads.
  localparam logic [1:0] MODE_DOT  = 2'b00;
  localparam logic [1:0] MODE_DASH = 2'b01;
  localparam logic [1:0] MODE_RSVD = 2'b10;
  localparam logic [1:0] MODE_GAP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } timer_state_e;

  localparam int unsigned DEF_WIDTH = 17;
  localparam logic [16:0] DEF_TAPS  = 17'h0002D;
  localparam logic [16:0] DEF_SEED  = 17'h1FFFF;
  localparam logic [16:0] DEF_TERM0 = 17'd24988;
  localparam logic [16:0] DEF_TERM1 = 17'd98941;
  localparam logic [16:0] DEF_TERM2 = 17'd98941;
  localparam logic [16:0] DEF_TERM3 = 17'd94171;

endpackage

// File: rtl/lfsr_timer_multi_next.sv
// Combinational Galois-LFSR next-state function, reusable by any timer.
module lfsr_galois_next
  import lfsr_timer_pkg::*;
#(
  parameter int unsigned     WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = DEF_TAPS
) (
  input  logic [WIDTH-1:0] lfsr,
  output logic [WIDTH-1:0] lfsr_next
);

  logic fb;
  assign fb = lfsr[WIDTH-1];

  // Shift left; the MSB feeds bit 0 and is xored into every tapped bit.
  always_comb begin
    lfsr_next[0] = fb;
    for (int i = 1; i < int'(WIDTH); i++) begin
      lfsr_next[i] = lfsr[i-1] ^ (TAPS[i] & fb);
    end
  end

endmodule

// File: rtl/lfsr_timer_multi.sv
// Multi-mode LFSR interval timer: one-shot/periodic timeout, idle-only reconfig,
// sticky wrap error when the terminal state is never reached.
module lfsr_timer_multi
  import lfsr_timer_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TERM0 = DEF_TERM0,
  parameter logic [WIDTH-1:0] TERM1 = DEF_TERM1,
  parameter logic [WIDTH-1:0] TERM2 = DEF_TERM2,
  parameter logic [WIDTH-1:0] TERM3 = DEF_TERM3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             periodic,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             reconfig,
  output logic             timeout,
  output logic             busy,
  output logic             cfg_ack,
  output logic             wrap_err,
  output logic [WIDTH-1:0] lfsr_state
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [WIDTH-1:0] term_q, term_d, term_sel;
  logic             timeout_q, timeout_d;
  logic             cfg_ack_q, cfg_ack_d;
  logic             wrap_err_q, wrap_err_d;

  lfsr_galois_next #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) u_next (
    .lfsr     (lfsr_q),
    .lfsr_next(lfsr_next)
  );

  // Terminal state candidate for the requested mode.
  always_comb begin
    term_sel = TERM1;
    unique case (mode)
      MODE_DOT:  term_sel = TERM0;
      MODE_DASH: term_sel = TERM1;
      MODE_RSVD: term_sel = TERM2;
      MODE_GAP:  term_sel = TERM3;
      default:   term_sel = TERM1;
    endcase
  end

  // Next-state: clear beats reconfig, which beats normal counting.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    term_d     = term_q;
    timeout_d  = 1'b0;
    cfg_ack_d  = 1'b0;
    wrap_err_d = wrap_err_q;

    if (clear) begin
      state_d = IDLE;
      lfsr_d  = SEED;
    end else if (reconfig && (state_q == IDLE) && !enable) begin
      term_d     = term_sel;
      cfg_ack_d  = 1'b1;
      wrap_err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (state_q == IDLE) begin
            lfsr_d = SEED;
          end
          // Leaving IDLE performs the first step in the same edge.
          if (enable) begin
            state_d = RUN;
            if (lfsr_q == term_q) begin
              lfsr_d    = SEED;
              timeout_d = 1'b1;
              if (!periodic) begin
                state_d = DONE;
              end
            end else begin
              lfsr_d = lfsr_next;
              // Back at SEED without a match: terminal state is unreachable.
              if (lfsr_next == SEED) begin
                wrap_err_d = 1'b1;
              end
            end
          end
        end
        DONE: begin
          lfsr_d = SEED;
          if (!enable) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          lfsr_d  = SEED;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      term_q     <= TERM1;
      timeout_q  <= 1'b0;
      cfg_ack_q  <= 1'b0;
      wrap_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      term_q     <= term_d;
      timeout_q  <= timeout_d;
      cfg_ack_q  <= cfg_ack_d;
      wrap_err_q <= wrap_err_d;
    end
  end

  assign timeout    = timeout_q;
  assign busy       = (state_q == RUN);
  assign cfg_ack    = cfg_ack_q;
  assign wrap_err   = wrap_err_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_timer_multi.sv
// Self-checking bench for lfsr_timer_multi: a sequence-index model plus literal checks.
module tb_lfsr_timer_multi;

  localparam int W = 17;
  localparam int NMAX = 131071;
  localparam logic [W-1:0] SEED = 17'h1FFFF;
  localparam logic [W-1:0] TAPS = 17'h0002D;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main DUT inputs/outputs.
  logic         rst, enable, periodic, clear, reconfig;
  logic [1:0]   mode;
  logic         timeout, busy, cfg_ack, wrap_err;
  logic [W-1:0] lfsr_state;

  // Small DUT for the unreachable-terminal wrap check.
  logic       s_rst, s_enable, s_periodic, s_clear, s_reconfig;
  logic [1:0] s_mode;
  logic       s_timeout, s_busy, s_cfg_ack, s_wrap_err;
  logic [5:0] s_lfsr_state;

  lfsr_timer_multi #(
    .TERM1(17'h1FFD3)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .enable    (enable),
    .periodic  (periodic),
    .clear     (clear),
    .mode      (mode),
    .reconfig  (reconfig),
    .timeout   (timeout),
    .busy      (busy),
    .cfg_ack   (cfg_ack),
    .wrap_err  (wrap_err),
    .lfsr_state(lfsr_state)
  );

  lfsr_timer_multi #(
    .WIDTH(6),
    .TAPS (6'h03),
    .SEED (6'h3F),
    .TERM0(6'h00),
    .TERM1(6'h00),
    .TERM2(6'h00),
    .TERM3(6'h00)
  ) dut_small (
    .clock     (clock),
    .rst       (s_rst),
    .enable    (s_enable),
    .periodic  (s_periodic),
    .clear     (s_clear),
    .mode      (s_mode),
    .reconfig  (s_reconfig),
    .timeout   (s_timeout),
    .busy      (s_busy),
    .cfg_ack   (s_cfg_ack),
    .wrap_err  (s_wrap_err),
    .lfsr_state(s_lfsr_state)
  );

  int total = 0;
  int bad = 0;

  // Model: position in the LFSR sequence instead of the register value.
  logic [W-1:0] seq [NMAX];
  int           period;
  logic [W-1:0] terms [4];

  typedef struct packed {
    logic [1:0]   st;    // 0 idle, 1 run, 2 done
    int           pos;
    int           k;     // index of terminal state, -1 if never reached
    logic [W-1:0] term;
    logic         to;
    logic         ack;
    logic         werr;
  } mdl_t;

  mdl_t m;
  bit   m_valid = 1'b0;

  function automatic logic [31:0] gnext(logic [31:0] l, logic [31:0] tp, int w);
    logic [31:0] mask, r;
    mask = (32'd1 << w) - 32'd1;
    r = (l << 1) & mask;
    if (l[w-1]) r = (r ^ (tp & ~32'd1)) | 32'd1;
    return r & mask;
  endfunction

  function automatic int find_idx(logic [W-1:0] t);
    for (int i = 0; i < period; i++) if (seq[i] == t) return i;
    return -1;
  endfunction

  function automatic mdl_t model_step(mdl_t c, logic r, logic en, logic per, logic clr,
                                      logic rc, logic [1:0] md);
    mdl_t n;
    n = c;
    n.to = 1'b0;
    n.ack = 1'b0;
    if (r) begin
      n.st = 2'd0; n.pos = 0; n.term = terms[1]; n.k = find_idx(terms[1]); n.werr = 1'b0;
    end else if (clr) begin
      n.st = 2'd0; n.pos = 0;
    end else if (rc && c.st == 2'd0 && !en) begin
      n.term = terms[md]; n.k = find_idx(terms[md]); n.ack = 1'b1; n.werr = 1'b0;
    end else if (c.st == 2'd2) begin
      if (!en) n.st = 2'd0;
    end else if (en) begin
      n.st = 2'd1;
      if (c.pos == c.k) begin
        n.pos = 0; n.to = 1'b1;
        if (!per) n.st = 2'd2;
      end else begin
        n.pos = (c.pos + 1) % period;
        if (n.pos == 0) n.werr = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model, wait past the edge, compare every output.
  task automatic tick();
    m = model_step(m, rst, enable, periodic, clear, reconfig, mode);
    m_valid = m_valid | rst;
    @(posedge clock);
    #1;
    if (m_valid) begin
      check("model lfsr", 32'(lfsr_state), 32'(seq[m.pos]));
      check("model timeout", 32'(timeout), 32'(m.to));
      check("model busy", 32'(busy), 32'(m.st == 2'd1));
      check("model cfg_ack", 32'(cfg_ack), 32'(m.ack));
      check("model wrap_err", 32'(wrap_err), 32'(m.werr));
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, " lfsr"}, 32'(lfsr_state), 32'h1FFFF);
    check({tag, " timeout"}, 32'(timeout), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " cfg_ack"}, 32'(cfg_ack), 32'd0);
    check({tag, " wrap_err"}, 32'(wrap_err), 32'd0);
  endtask

  initial begin
    int k0, n, to_cnt, p6;
    logic [W-1:0] frozen, prev;
    logic [31:0] sl;

    terms[0] = 17'd24988; terms[1] = 17'h1FFD3; terms[2] = 17'd98941; terms[3] = 17'd94171;
    seq[0] = SEED;
    period = NMAX;
    for (int i = 1; i < NMAX; i++) begin
      seq[i] = W'(gnext(32'(seq[i-1]), 32'(TAPS), W));
      if (seq[i] == SEED) begin
        period = i;
        break;
      end
    end
    check("model first step", 32'(seq[1]), 32'h1FFD3);

    rst = 1'b1; enable = 1'b0; periodic = 1'b0; clear = 1'b0; reconfig = 1'b0; mode = 2'b01;
    s_rst = 1'b1; s_enable = 1'b0; s_periodic = 1'b0; s_clear = 1'b0; s_reconfig = 1'b0;
    s_mode = 2'b01;

    // Reset for two cycles.
    tick(); tick();
    check_reset_vals("reset");

    // One-shot, terminal one step from SEED.
    rst = 1'b0; enable = 1'b1;
    tick();
    check("first step lfsr", 32'(lfsr_state), 32'h1FFD3);
    check("first step busy", 32'(busy), 32'd1);
    tick();
    check("oneshot timeout", 32'(timeout), 32'd1);
    check("oneshot busy", 32'(busy), 32'd0);
    tick();
    check("done timeout low", 32'(timeout), 32'd0);
    check("done busy", 32'(busy), 32'd0);
    enable = 1'b0;
    tick();

    // Periodic: pulse every 2 cycles for 10 periods.
    periodic = 1'b1; enable = 1'b1; to_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (timeout) to_cnt++;
    end
    check("periodic pulse count", 32'(to_cnt), 32'd10);
    enable = 1'b0; clear = 1'b1;
    tick();
    check("clear busy", 32'(busy), 32'd0);
    clear = 1'b0; periodic = 1'b0;

    // Reconfig while RUN (paused) is ignored.
    enable = 1'b1;
    tick();
    enable = 1'b0; reconfig = 1'b1; mode = 2'b00;
    tick();
    check("reconfig in run ack", 32'(cfg_ack), 32'd0);
    check("reconfig in run busy", 32'(busy), 32'd1);
    reconfig = 1'b0; enable = 1'b1;
    tick();
    check("term unchanged timeout", 32'(timeout), 32'd1);
    enable = 1'b0;
    tick();
    // Reconfig in IDLE is accepted.
    reconfig = 1'b1;
    tick();
    check("reconfig idle ack", 32'(cfg_ack), 32'd1);
    reconfig = 1'b0;
    tick();
    check("ack one cycle", 32'(cfg_ack), 32'd0);

    // Run to TERM0 with a 5-cycle pause after 3 enabled edges.
    k0 = find_idx(17'd24988);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    frozen = lfsr_state;
    enable = 1'b0; to_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (timeout) to_cnt++;
    end
    check("pause frozen lfsr", 32'(lfsr_state), 32'(frozen));
    check("pause busy", 32'(busy), 32'd1);
    check("pause no timeout", 32'(to_cnt), 32'd0);
    enable = 1'b1; n = 0; prev = lfsr_state;
    while (!timeout && n < k0 + 20) begin
      prev = lfsr_state;
      tick();
      n++;
    end
    if (!timeout) begin
      bad++; total++;
      $display("FAIL term0 wait: got no timeout want timeout within %0d edges", k0 + 20);
    end else begin
      check("term0 edge count", 32'(3 + n), 32'(k0 + 1));
      check("term0 end state", 32'(prev), 32'd24988);
    end
    enable = 1'b0;
    tick();

    // Mid-run reset.
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    check_reset_vals("midrun reset");
    rst = 1'b0;
    tick(); tick();
    check("post reset term1 timeout", 32'(timeout), 32'd1);
    enable = 1'b0;
    tick();

    // Unreachable terminal: wrap_err after a full period.
    sl = 32'h3F; p6 = 0;
    do begin
      sl = gnext(sl, 32'h03, 6);
      p6++;
    end while (sl != 32'h3F && p6 < 64);
    check("small period", 32'(p6), 32'd63);
    s_rst = 1'b0; s_enable = 1'b1;
    for (int i = 0; i < p6 - 1; i++) tick();
    check("wrap_err before wrap", 32'(s_wrap_err), 32'd0);
    tick();
    check("wrap_err after wrap", 32'(s_wrap_err), 32'd1);
    check("small back at seed", 32'(s_lfsr_state), 32'h3F);
    check("small no timeout", 32'(s_timeout), 32'd0);
    s_enable = 1'b0; s_clear = 1'b1;
    tick();
    check("wrap_err kept by clear", 32'(s_wrap_err), 32'd1);
    check("small clear busy", 32'(s_busy), 32'd0);
    s_clear = 1'b0; s_reconfig = 1'b1;
    tick();
    check("small reconfig ack", 32'(s_cfg_ack), 32'd1);
    check("wrap_err cleared", 32'(s_wrap_err), 32'd0);
    s_reconfig = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_timer_multi.md
Name: lfsr_timer_multi

Overview:
- Parametrised Galois-LFSR interval timer for Morse symbol timing (dot/dash/gap windows).
- LFSR width, tap mask, seed and four per-mode terminal states are all parameters.
- Adds one-shot/periodic operation, synchronous clear, idle-only reconfiguration with acknowledge, and a sticky wrap-error flag for terminal states the sequence never reaches.
- Sits between the timing controller and the symbol decoder; timeout is a one-cycle pulse.

Parameters:
- WIDTH, 17, LFSR width in bits (>= 4).
- TAPS, 17'h0002D, Galois tap mask. Bit i set means bit i receives (LFSR[i-1] ^ fb). Bit 0 is always fb.
- SEED, {WIDTH{1'b1}}, restart state. Must be nonzero.
- TERM0, 17'd24988, terminal LFSR state for mode 2'b00.
- TERM1, 17'd98941, terminal state for mode 2'b01; also the reset default.
- TERM2, 17'd98941, terminal state for mode 2'b10.
- TERM3, 17'd94171, terminal state for mode 2'b11.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  count enable.
- periodic  in  1  1 = auto-restart after timeout; 0 = one-shot.
- clear  in  1  synchronous restart to IDLE.
- mode  in  2  selects TERM0..TERM3 on reconfig.
- reconfig  in  1  load terminal state from mode.
- timeout  out  1  one-cycle pulse when the terminal state is reached.
- busy  out  1  high in RUN.
- cfg_ack  out  1  one-cycle pulse when a reconfig is accepted.
- wrap_err  out  1  sticky: full period elapsed without hitting the terminal state.
- lfsr_state  out  WIDTH  current LFSR register, for debug.

Behaviour:
- Next-state function, with fb = L[WIDTH-1]:
  - L'[0] = fb.
  - L'[i] = L[i-1] ^ (TAPS[i] & fb).
- Reset (rst=1 at edge):
  - Outputs: lfsr=SEED, term_q=TERM1, state=IDLE, timeout=0, busy=0, cfg_ack=0, wrap_err=0.
  - rst overrides every other input, including mid-count.
- Priority at each edge: rst > clear > reconfig > FSM.
- clear: lfsr=SEED, state=IDLE, timeout=0. term_q and wrap_err are kept.
- Reconfig acceptance:
  - Accepted only when state==IDLE and enable==0: term_q<=TERMmode, cfg_ack=1 next cycle, wrap_err<=0.
  - Otherwise ignored: no ack, term_q unchanged.
- FSM state IDLE:
  - lfsr held at SEED.
  - enable=1: go to RUN and perform the first step or match check in the same edge (same rules as RUN).
- FSM state RUN, enable=1:
  - If lfsr==term_q: lfsr<=SEED and timeout<=1. Then periodic=1 stays in RUN; periodic=0 goes to DONE.
  - Else: lfsr<=next(lfsr), timeout<=0.
  - If next(lfsr)==SEED while term_q != lfsr: wrap_err<=1 (sticky) and counting continues.
- FSM state RUN, enable=0: lfsr held (pause), timeout=0, state stays RUN.
- FSM state DONE: lfsr=SEED, timeout=0, busy=0. enable=0 returns to IDLE; enable=1 waits in DONE.
- Timing:
  - If term_q is k steps from SEED, timeout is high in the cycle after the (k+1)th enabled edge counted from the IDLE exit.
  - Periodic period is k+1 enabled cycles.
  - term_q==SEED gives timeout after 1 enabled edge and a period of 1 in periodic mode.
- Outputs:
  - busy = (state==RUN), registered.
  - timeout and cfg_ack are never high for more than one cycle in one-shot mode.

Decomposition:
- Package lfsr_timer_pkg holds:
  - mode encodings MODE_DOT=2'b00, MODE_DASH=2'b01, MODE_RSVD=2'b10, MODE_GAP=2'b11;
  - FSM state enum IDLE/RUN/DONE;
  - default TAPS, SEED and TERM constants.
- Sub-module lfsr_galois_next: combinational next-state function, parametrised by WIDTH and TAPS, reusable by other timers.

Test Plan:
- Reset value check: assert rst for 2 cycles -> lfsr_state=17'h1FFFF, timeout=0, busy=0, cfg_ack=0, wrap_err=0.
- First-step value: TERM1 overridden to 17'h1FFD3 (one step from SEED), enable=1, periodic=0 -> lfsr_state=17'h1FFD3 after edge 1; timeout=1 after edge 2 for exactly one cycle; busy=0 from then on.
- Periodic mode: TERM=17'h1FFD3, periodic=1, enable held high -> timeout pulses every 2 cycles for 10 periods with no gaps.
- Pause mid-count: enable=0 for 5 cycles mid-run -> lfsr_state frozen, no timeout, busy=1; timeout is delayed by exactly 5 cycles.
- Reconfig gating:
  - mode=2'b00, reconfig while RUN -> no cfg_ack, term unchanged.
  - Same request in IDLE with enable=0 -> cfg_ack pulse; the next run ends on 24988.
- Unreachable terminal state and mid-run reset:
  - TERM=0 -> wrap_err=1 after 2^17-1 enabled steps; a following reconfig clears it.
  - rst mid-RUN -> all reset values on the next edge.
